// File: rtl/dmem_responder.sv
// dmem_responder: target side of the core's load/store port.
// One request at a time over valid/ready; the response appears RD_LATENCY
// cycles after accept. Stores commit byte-wise at the accept edge. Loads
// sample the addressed word at the accept edge into a holding register.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we[3:0]           byte enables, 0 = load
//   req_addr[31:0]        byte address, bits [1:0] ignored for word select
//   req_wdata[31:0]       lane-aligned store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata[31:0]       loaded word, 0 for stores and errors
//   rsp_err               illegal mask or out-of-range address
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'd4;
  // WAIT lasts RD_LATENCY-1 cycles; counter runs 0 .. RD_LATENCY-2.
  localparam logic [3:0]  WAIT_LAST = 4'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
  localparam bit          USE_WAIT  = (RD_LATENCY > 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic        in_range, mask_ok, err, accept, is_load;
  logic [31:0] rdata_q;
  logic        err_q;

  // Request decode. Offset is taken in 32 bits; a below-base address is
  // caught by the explicit compare rather than relying on wrap.
  always_comb begin
    offset   = req_addr - BASE_ADDR;
    in_range = (req_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    idx      = offset[AW+1:2];
    case (req_we)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
      default:                   mask_ok = 1'b0;
    endcase
    err     = ~in_range | ~mask_ok;
    is_load = (req_we == 4'b0000);
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  // Reset blocks accept so a store cannot commit during a reset cycle.
  assign accept    = req_valid & req_ready & reset_n;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (accept) begin
        state_nx = USE_WAIT ? WAIT : RESP;
        cnt_nx   = 4'd0;
      end
      WAIT: begin
        if (cnt == WAIT_LAST) state_nx = RESP;
        else                  cnt_nx   = cnt + 4'd1;
      end
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Array has no reset: contents survive reset by design.
  always_ff @(posedge clk) begin
    if (accept && !err && !is_load) begin
      for (int b = 0; b < 4; b++)
        if (req_we[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
    end
  end

  // Response holding registers; cleared on handshake so outputs idle at 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      err_q   <= err;
      rdata_q <= (!err && is_load) ? mem[idx] : 32'h0;
    end else if (state == RESP && rsp_ready) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          LAT   = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int passed = 0;
  int total  = 0;

  // Reference: word store keyed by word index.
  logic [31:0] mdl [int];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic void model(input logic [3:0] we, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                output logic e, output logic [31:0] rd);
    logic [3:0] legal [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    bit ok = 0;
    longint off;
    int w;
    foreach (legal[i]) if (legal[i] == we) ok = 1;
    off = longint'(addr) - longint'(BASE);
    rd  = 32'h0;
    e   = !ok || off < 0 || off >= longint'(DEPTH) * 4;
    if (e) return;
    w = int'(off / 4);
    if (we == 4'h0) rd = mdl.exists(w) ? mdl[w] : 32'h0;
    else begin
      logic [31:0] cur = mdl.exists(w) ? mdl[w] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (we[b]) cur[8*b +: 8] = wdata[8*b +: 8];
      mdl[w] = cur;
    end
  endfunction

  // One full transaction; stall = cycles rsp_ready held low after rsp_valid.
  task automatic do_req(input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall, input string tag);
    logic        e_err;
    logic [31:0] e_rd;
    int lat = 0;
    model(we, addr, wdata, e_err, e_rd);
    @(negedge clk);
    chk({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    chk({tag, "_lat"}, 32'(lat), 32'(LAT));
    chk({tag, "_rd"},  rsp_rdata, e_rd);
    chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e_err});
    if (stall > 0) begin
      // Requests offered during backpressure must be ignored.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 4'hF; req_addr = 32'h100; req_wdata = 32'hBAD0BAD0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk({tag, "_st_v"},   {31'b0, rsp_valid}, 32'd1);
        chk({tag, "_st_rd"},  rsp_rdata, e_rd);
        chk({tag, "_st_err"}, {31'b0, rsp_err}, {31'b0, e_err});
        chk({tag, "_st_rdy"}, {31'b0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_post_v"},   {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_post_rdy"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_post_rd"},  rsp_rdata, 32'h0);
  endtask

  initial begin
    logic [3:0] legal   [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    logic [3:0] illegal [8] = '{4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE};
    logic        e_err;
    logic [31:0] e_rd;

    reset_n = 1'b0; req_valid = 1'b0; req_we = 4'h0; req_addr = 32'h0;
    req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy",  {31'b0, req_ready}, 32'd1);
    chk("rst_v",    {31'b0, rsp_valid}, 32'd0);
    chk("rst_rd",   rsp_rdata, 32'h0);
    chk("rst_err",  {31'b0, rsp_err}, 32'd0);
    reset_n = 1'b1;

    do_req(4'hF, 32'h10, 32'hDEADBEEF, 0, "t1_st");
    do_req(4'h0, 32'h10, 32'h0, 0, "t1_ld");
    chk("t1_val", mdl[4], 32'hDEADBEEF);

    do_req(4'h2, 32'h10, 32'h0000AA00, 0, "t2_st");
    do_req(4'h0, 32'h10, 32'h0, 0, "t2_ld");
    do_req(4'h0, 32'h12, 32'h0, 0, "t2_ld12");
    chk("t2_val", mdl[4], 32'hDEADAAEF);

    do_req(4'h5, 32'h10, 32'hFFFFFFFF, 0, "t3_bad");
    do_req(4'h0, 32'h10, 32'h0, 0, "t3_ld");

    do_req(4'hF, 32'hFFC, 32'hCAFEF00D, 0, "t4_st");
    do_req(4'h0, 32'h1000, 32'h0, 0, "t4_oor");
    do_req(4'h0, 32'hFFC, 32'h0, 0, "t4_top");

    do_req(4'h0, 32'h10, 32'h0, 3, "t5_bp");

    // Reset while in WAIT: response dropped, store already committed.
    model(4'hF, 32'h20, 32'h12345678, e_err, e_rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = 4'hF; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("t6_wait_v", {31'b0, rsp_valid}, 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_v",   {31'b0, rsp_valid}, 32'd0);
    chk("t6_rst_rdy", {31'b0, req_ready}, 32'd1);
    reset_n = 1'b1;
    do_req(4'h0, 32'h20, 32'h0, 0, "t6_ld");
    chk("t6_val", mdl[8], 32'h12345678);

    // Randomized traffic over 16 words at 0x100.
    for (int w = 0; w < 16; w++) do_req(4'hF, 32'h100 + 32'(w * 4), $urandom, 0, "init");
    for (int n = 0; n < 60; n++) begin
      int kind = int'($urandom_range(0, 9));
      logic [31:0] a = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      int st = int'($urandom_range(0, 2));
      if (kind == 0)      do_req(illegal[$urandom_range(0, 7)], a, $urandom, st, "rnd_bad");
      else if (kind == 1) do_req(4'h0, 32'h1000 + 32'($urandom_range(0, 32'hFFFF)), 32'h0, st, "rnd_oor");
      else if (kind < 5)  do_req(4'h0, a, 32'h0, st, "rnd_ld");
      else                do_req(legal[$urandom_range(1, 7)], a, $urandom, st, "rnd_st");
    end
    for (int w = 0; w < 16; w++) do_req(4'h0, 32'h100 + 32'(w * 4), 32'h0, 0, "final_ld");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
